display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display. It drives `dig_sel` into the nibble group selector and drives the matching active-low digit anodes. It also double-buffers the 16-bit display word so the digits only change at frame boundaries, which prevents tearing. It sits upstream of the group selector and seven-segment decoder, between the datapath producing the display word and the board pins.

## Interface
- `PRESCALE`, 50000: clock cycles each digit is held (digit period); legal range ≥ `DEAD`+2.
- `DEAD`, 4: blanking cycles at the start of each digit period (anti-ghosting); legal range ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scan enable; low blanks the display.
- `value`  in  16  new display word (digit 0 = `value[3:0]`, digit 3 = `value[15:12]`).
- `value_valid`  in  1  one-cycle strobe; capture `value` into the pending buffer.
- `frame_value`  out  16  word currently displayed; connects to the group selector `value` input.
- `dig_sel`  out  2  current digit index; connects to the group selector `dig_sel` input.
- `anode_n`  out  4  active-low one-hot anode drive; bit i low ⇔ digit i lit.
- `frame_start`  out  1  one-cycle pulse when a new frame (digit 0) begins.

## Operation
- Prescaler `pcnt` counts 0..`PRESCALE`-1. `tick` = (`pcnt` == `PRESCALE`-1) & `enable`. `pcnt` wraps to 0 on `tick`.
- On `tick`, `dig_sel` increments modulo 4 (3→0 wraps).
- Frame boundary = `tick` with `dig_sel` == 3. At the boundary:
  - `frame_value` loads from the pending buffer if the pending flag is set; the flag then clears.
  - `frame_start` pulses high the following cycle, aligned with `dig_sel` becoming 0.
- Pending buffer: `value_valid` captures `value` and sets the flag. Several strobes within one frame: last wins.
- `value_valid` coincident with the frame boundary: that cycle's `value` loads straight into `frame_value`, and the flag ends cleared.
- Anode drive, all outputs registered:
  - `anode_n` = all ones while `pcnt` < `DEAD`.
  - Otherwise `anode_n` = ~(1 << `dig_sel`).
- `enable` low:
  - `pcnt` forced to 0; `dig_sel` and `frame_value` hold; `anode_n` = 4'b1111; no `frame_start`.
  - The pending buffer still accepts `value_valid`.
- `enable` re-asserted: the scan resumes at the held `dig_sel` with a full dead period first.
- States are implicit in (`dig_sel`, `pcnt`): per digit, BLANK (`pcnt` < `DEAD`) → ON (`DEAD` ≤ `pcnt` ≤ `PRESCALE`-1) → next digit's BLANK.
- Counter width: `pcnt` is $clog2(`PRESCALE`) bits. No arithmetic exceeds that width.

## Timing
- Reset values: `pcnt` 0, `dig_sel` 2'b00, `anode_n` 4'b1111, `frame_value` 16'h0000, pending flag 0, `frame_start` 0.
- Reset is asynchronous on assertion and applies mid-digit or mid-frame; the pending word is lost.
- Output latency: `dig_sel`, `anode_n` and `frame_start` all update on the clock edge after the condition is evaluated. They change together, so `dig_sel` and `anode_n` are never skewed.
- `frame_value` changes only in the same edge where `dig_sel` goes 3→0. `anode_n` is all-off for `DEAD` cycles around that edge.
- Full frame period = 4 × `PRESCALE` cycles. Lit duty per digit = (`PRESCALE` − `DEAD`) / (4 × `PRESCALE`).
- Latency from `value_valid` to display: at most one full frame plus one cycle.

## Configuration
- `DISPLAY_SCAN_LZ_BLANK_EN` defined: leading-zero blanking.
  - Digit i is suppressed (its `anode_n` bit held high) when `frame_value` nibbles i..3 are all zero and i ≠ 0.
  - Digit 0 is always shown. `dig_sel` timing is unchanged.
- Not defined: all four digits are lit in turn regardless of value.

## Test plan
Benches run with `PRESCALE`=8, `DEAD`=2.
- **Reset:** assert `reset_n`=0 mid-digit 2 → all outputs return to reset values immediately (asynchronously). After release, `anode_n`=1111 for 2 cycles, then 1110.
- **Scan sequence:** `enable`=1, no `value_valid` → `dig_sel` steps 0,1,2,3,0 every 8 cycles. Anode pattern per digit is 2× 1111, then 6× 1110/1101/1011/0111. `frame_start` pulses every 32 cycles.
- **Buffering:** `value_valid` with 16'h1234 while `dig_sel`=1 → `frame_value` stays 0 until the 3→0 wrap, then becomes 16'h1234. Two strobes 16'hAAAA then 16'h5555 in one frame → 16'h5555 is loaded.
- **Coincidence:** `value_valid` with 16'hBEEF in the frame-boundary cycle → `frame_value`=16'hBEEF on the next edge; the pending flag is clear.
- **Enable gating:** drop `enable` for 5 cycles during digit 2 → `anode_n`=1111 and `dig_sel`=2 hold. On re-enable, 2 dead cycles follow, then 1011 for 6 cycles.
- **Leading-zero blanking** (macro defined): `frame_value`=16'h0007 → only digit 0 lights. 16'h0000 → digit 0 lights. 16'h0100 → digits 0–2 light, digit 3 stays 1 (off).

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller with a frame-synchronous display buffer.
// Define DISPLAY_SCAN_LZ_BLANK_EN to suppress leading zero digits (digit 0 always shown).
module display_scan_ctrl #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned DEAD     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic [15:0] frame_value,
    output logic [1:0]  dig_sel,
    output logic [3:0]  anode_n,
    output logic        frame_start
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PDEAD = PW'(DEAD);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    anode_q, anode_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic          fstart_q, fstart_d;
    logic          tick;
    logic          boundary;
    logic [3:0]    lit;

    assign tick     = enable && (pcnt_q == PMAX);
    assign boundary = tick && (dig_q == 2'd3);

    always_comb begin
        pcnt_d     = '0;
        dig_d      = dig_q;
        frame_d    = frame_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        fstart_d   = boundary;

        if (enable && !tick) begin
            pcnt_d = pcnt_q + PW'(1);
        end
        if (tick) begin
            dig_d = dig_q + 2'd1;
        end

        // A strobe on the boundary bypasses the buffer and wins over stale data
        if (boundary) begin
            pend_d = 1'b0;
            if (value_valid) begin
                frame_d = value;
            end else if (pend_q) begin
                frame_d = pend_val_q;
            end
        end else if (value_valid) begin
            pend_val_d = value;
            pend_d     = 1'b1;
        end
    end

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
    always_comb begin
        lit    = 4'b0001;
        lit[1] = |frame_d[15:4];
        lit[2] = |frame_d[15:8];
        lit[3] = |frame_d[15:12];
    end
`else
    assign lit = 4'b1111;
`endif

    // Anodes derive from next-state values so they stay aligned with dig_sel
    always_comb begin
        anode_d = 4'b1111;
        if (enable && (pcnt_d >= PDEAD)) begin
            anode_d = ~(4'b0001 << dig_d) | ~lit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q     <= '0;
            dig_q      <= 2'd0;
            anode_q    <= 4'b1111;
            frame_q    <= 16'h0000;
            pend_val_q <= 16'h0000;
            pend_q     <= 1'b0;
            fstart_q   <= 1'b0;
        end else begin
            pcnt_q     <= pcnt_d;
            dig_q      <= dig_d;
            anode_q    <= anode_d;
            frame_q    <= frame_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            fstart_q   <= fstart_d;
        end
    end

    assign frame_value = frame_q;
    assign dig_sel     = dig_q;
    assign anode_n     = anode_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with PRESCALE=8, DEAD=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_display_scan_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [15:0] value;
    logic        value_valid;
    logic [15:0] frame_value;
    logic [1:0]  dig_sel;
    logic [3:0]  anode_n;
    logic        frame_start;

    int passed;
    int total;
    int k;

    display_scan_ctrl #(
        .PRESCALE(8),
        .DEAD(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .value(value),
        .value_valid(value_valid),
        .frame_value(frame_value),
        .dig_sel(dig_sel),
        .anode_n(anode_n),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
        k += n;
    endtask

    task automatic goto(input int target);
        while (k < target) tick_n(1);
    endtask

    task automatic strobe(input logic [15:0] v);
        value       = v;
        value_valid = 1'b1;
        tick_n(1);
        value_valid = 1'b0;
    endtask

    task automatic do_reset;
        reset_n     = 1'b0;
        enable      = 1'b1;
        value_valid = 1'b0;
        value       = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
    endtask

    task automatic test_reset;
        do_reset();
        strobe(16'h9999);
        goto(32);
        strobe(16'h7777);
        goto(51);
        total++;
        if (dig_sel !== 2'd2 || frame_value !== 16'h9999)
            $display("FAIL pre_reset dig=%0d frame=%h want 2 9999",
                     dig_sel, frame_value);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (dig_sel !== 2'd0 || anode_n !== 4'b1111 ||
            frame_value !== 16'h0000 || frame_start !== 1'b0)
            $display("FAIL async_reset dig=%0d an=%b fv=%h fs=%b",
                     dig_sel, anode_n, frame_value, frame_start);
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        total++;
        if (anode_n !== 4'b1111)
            $display("FAIL rel_k0 anode=%b want 1111", anode_n);
        else passed++;
        tick_n(1);
        total++;
        if (anode_n !== 4'b1111)
            $display("FAIL rel_k1 anode=%b want 1111", anode_n);
        else passed++;
        tick_n(1);
        total++;
        if (anode_n !== 4'b1110)
            $display("FAIL rel_k2 anode=%b want 1110", anode_n);
        else passed++;
        goto(32);
        total++;
        if (frame_value !== 16'h0000 || dig_sel !== 2'd0)
            $display("FAIL pend_lost fv=%h dig=%0d want 0000 0",
                     frame_value, dig_sel);
        else passed++;
    endtask

    task automatic test_scan;
        logic [1:0] ed;
        logic [3:0] ea;
        logic       ef;
        do_reset();
        for (int i = 0; i <= 40; i++) begin
            ed = 2'(i / 8);
            ea = 4'b1111;
            if (i % 8 >= 2) ea = ~(4'b0001 << ed);
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
            if (ed != 2'd0) ea = 4'b1111;
`endif
            ef = (i > 0) && (i % 32 == 0);
            total++;
            if (dig_sel !== ed || anode_n !== ea || frame_start !== ef)
                $display("FAIL scan k=%0d dig=%0d an=%b fs=%b want %0d %b %b",
                         k, dig_sel, anode_n, frame_start, ed, ea, ef);
            else passed++;
            tick_n(1);
        end
    endtask

    task automatic test_buffering;
        do_reset();
        goto(10);
        strobe(16'h1234);
        goto(31);
        total++;
        if (frame_value !== 16'h0000)
            $display("FAIL buf_hold fv=%h want 0000", frame_value);
        else passed++;
        tick_n(1);
        total++;
        if (frame_value !== 16'h1234 || dig_sel !== 2'd0)
            $display("FAIL buf_load fv=%h dig=%0d want 1234 0",
                     frame_value, dig_sel);
        else passed++;
        goto(40);
        strobe(16'hAAAA);
        goto(45);
        strobe(16'h5555);
        goto(63);
        total++;
        if (frame_value !== 16'h1234)
            $display("FAIL buf_hold2 fv=%h want 1234", frame_value);
        else passed++;
        tick_n(1);
        total++;
        if (frame_value !== 16'h5555)
            $display("FAIL last_wins fv=%h want 5555", frame_value);
        else passed++;
    endtask

    task automatic test_coincidence;
        goto(80);
        strobe(16'h1111);
        goto(95);
        strobe(16'hBEEF);
        total++;
        if (frame_value !== 16'hBEEF || frame_start !== 1'b1)
            $display("FAIL coinc fv=%h fs=%b want beef 1",
                     frame_value, frame_start);
        else passed++;
        goto(128);
        total++;
        if (frame_value !== 16'hBEEF)
            $display("FAIL coinc_clr fv=%h want beef", frame_value);
        else passed++;
    endtask

    task automatic test_enable_gating;
        logic [3:0] ea;
        logic [1:0] ed;
        do_reset();
        goto(18);
        total++;
        if (dig_sel !== 2'd2 || anode_n !== 4'b1011)
            $display("FAIL gate_pre dig=%0d an=%b want 2 1011",
                     dig_sel, anode_n);
        else passed++;
        enable = 1'b0;
        strobe(16'h4321);
        for (int i = 1; i <= 5; i++) begin
            if (i > 1) tick_n(1);
            total++;
            if (anode_n !== 4'b1111 || dig_sel !== 2'd2 ||
                frame_start !== 1'b0)
                $display("FAIL gate_off i=%0d an=%b dig=%0d fs=%b",
                         i, anode_n, dig_sel, frame_start);
            else passed++;
        end
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick_n(1);
            ea = (i == 1 || i == 8) ? 4'b1111 : 4'b1011;
            ed = (i == 8) ? 2'd3 : 2'd2;
            total++;
            if (anode_n !== ea || dig_sel !== ed)
                $display("FAIL gate_on i=%0d an=%b dig=%0d want %b %0d",
                         i, anode_n, dig_sel, ea, ed);
            else passed++;
        end
        total++;
        if (frame_value !== 16'h0000)
            $display("FAIL gate_fv fv=%h want 0000", frame_value);
        else passed++;
        tick_n(8);
        total++;
        if (frame_value !== 16'h4321 || dig_sel !== 2'd0 ||
            frame_start !== 1'b1)
            $display("FAIL gate_pend fv=%h dig=%0d fs=%b want 4321 0 1",
                     frame_value, dig_sel, frame_start);
        else passed++;
    endtask

`ifdef DISPLAY_SCAN_LZ_BLANK_EN
    task automatic test_lz_blank;
        logic [3:0] exp_a [12];
        exp_a = '{4'b1110, 4'b1111, 4'b1111, 4'b1111,
                  4'b1110, 4'b1111, 4'b1111, 4'b1111,
                  4'b1110, 4'b1101, 4'b1011, 4'b1111};
        do_reset();
        goto(2);
        strobe(16'h0007);
        goto(40);
        strobe(16'h0000);
        goto(70);
        strobe(16'h0100);
        for (int i = 0; i < 12; i++) begin
            goto(36 + 8 * i);
            total++;
            if (anode_n !== exp_a[i])
                $display("FAIL lz i=%0d an=%b want %b",
                         i, anode_n, exp_a[i]);
            else passed++;
        end
    endtask
`endif

    initial begin
        passed      = 0;
        total       = 0;
        k           = 0;
        reset_n     = 1'b0;
        enable      = 1'b0;
        value       = 16'h0000;
        value_valid = 1'b0;
        test_reset();
        test_scan();
        test_buffering();
        test_coincidence();
        test_enable_gating();
`ifdef DISPLAY_SCAN_LZ_BLANK_EN
        test_lz_blank();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
